// File: rtl/instr_exec_sequencer_if.sv
// Instruction-register read port and result stream shared by the
// execution sequencer (master) and its environment (slave).
interface instr_exec_sequencer_if #(
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5
);
  typedef struct packed {
    logic [3:0]       opc;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] rezultat;
  } instruction_t;

  logic [ADDR_W-1:0]       read_pointer;
  instruction_t            instruction_word;
  logic                    res_valid;
  logic                    res_ready;
  logic [ADDR_W-1:0]       res_addr;
  logic [3:0]              res_opcode;
  logic signed [RES_W-1:0] res_value;
  logic                    res_div_zero;

  modport master (
    output read_pointer, input instruction_word,
    output res_valid, input res_ready,
    output res_addr, res_opcode, res_value, res_div_zero
  );

  modport slave (
    input read_pointer, output instruction_word,
    input res_valid, output res_ready,
    input res_addr, res_opcode, res_value, res_div_zero
  );
endinterface

// File: rtl/instr_exec_sequencer.sv
// Walks an address window of the instruction register, executes each entry
// (single-cycle ALU or 32-step restoring divider) and streams the results.
module instr_exec_sequencer #(
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       count,
  instr_exec_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done
);
  localparam int STEP_W = $clog2(OP_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OP_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPT, S_EXEC, S_DIVIDE, S_OUT, S_FIN} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W:0]         remaining_reg;
  logic [ADDR_W-1:0]       read_pointer_reg, res_addr_reg;
  logic [3:0]              opc_reg;
  logic signed [OP_W-1:0]  op_a_reg, op_b_reg;
  logic signed [RES_W-1:0] res_value_reg;
  logic                    res_div_zero_reg;
  logic [OP_W-1:0]         quo_reg, dsor_reg;
  logic [OP_W:0]           rem_reg;
  logic [STEP_W-1:0]       step_reg;
  logic                    neg_quo_reg, neg_rem_reg;

  logic signed [RES_W-1:0] a_ext, b_ext, alu_result;
  logic                    alu_dz, go_divide;
  logic [OP_W-1:0]         abs_a, abs_b, quo_step;
  logic [OP_W:0]           rem_shift, rem_trial, rem_step;
  logic [RES_W-1:0]        quo_ext, rem_ext, div_result;

  always_comb begin
    a_ext      = {{(RES_W-OP_W){op_a_reg[OP_W-1]}}, op_a_reg};
    b_ext      = {{(RES_W-OP_W){op_b_reg[OP_W-1]}}, op_b_reg};
    alu_result = '0;
    alu_dz     = 1'b0;
    go_divide  = 1'b0;
    case (opc_reg)
      4'd0: alu_result = '0;
      4'd1: alu_result = a_ext;
      4'd2: alu_result = b_ext;
      4'd3: alu_result = a_ext + b_ext;
      4'd4: alu_result = a_ext - b_ext;
      4'd5: alu_result = a_ext * b_ext;
      4'd6, 4'd7: begin
        alu_dz    = (op_b_reg == '0);
        go_divide = (op_b_reg != '0);
      end
      default: alu_dz = 1'b1;
    endcase
    abs_a = op_a_reg[OP_W-1] ? -op_a_reg : op_a_reg;
    abs_b = op_b_reg[OP_W-1] ? -op_b_reg : op_b_reg;
  end

  // One restoring step on magnitudes; signs are reapplied on the final step.
  always_comb begin
    rem_shift = {rem_reg[OP_W-1:0], quo_reg[OP_W-1]};
    rem_trial = rem_shift - {1'b0, dsor_reg};
    if (!rem_trial[OP_W]) begin
      rem_step = rem_trial;
      quo_step = {quo_reg[OP_W-2:0], 1'b1};
    end else begin
      rem_step = rem_shift;
      quo_step = {quo_reg[OP_W-2:0], 1'b0};
    end
    quo_ext = {{(RES_W-OP_W){1'b0}}, quo_step};
    rem_ext = {{(RES_W-OP_W-1){1'b0}}, rem_step};
    if (opc_reg[0]) div_result = neg_rem_reg ? -rem_ext : rem_ext;
    else            div_result = neg_quo_reg ? -quo_ext : quo_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = (count != '0) ? S_ADDR : S_FIN;
      S_ADDR:   state_next = S_CAPT;
      S_CAPT:   state_next = S_EXEC;
      S_EXEC:   state_next = go_divide ? S_DIVIDE : S_OUT;
      S_DIVIDE: if (step_reg == LAST_STEP) state_next = S_OUT;
      S_OUT:    if (bus.res_ready) state_next = (remaining_reg == (ADDR_W+1)'(1)) ? S_FIN : S_ADDR;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_reg    <= '0;
      read_pointer_reg <= '0;
      res_addr_reg     <= '0;
      opc_reg          <= '0;
      op_a_reg         <= '0;
      op_b_reg         <= '0;
      res_value_reg    <= '0;
      res_div_zero_reg <= 1'b0;
      quo_reg          <= '0;
      dsor_reg         <= '0;
      rem_reg          <= '0;
      step_reg         <= '0;
      neg_quo_reg      <= 1'b0;
      neg_rem_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (start && count != '0) begin
          remaining_reg    <= count;
          read_pointer_reg <= start_addr;
        end
        S_CAPT: begin
          opc_reg      <= bus.instruction_word.opc;
          op_a_reg     <= bus.instruction_word.op_a;
          op_b_reg     <= bus.instruction_word.op_b;
          res_addr_reg <= read_pointer_reg;
        end
        S_EXEC: begin
          res_value_reg    <= alu_result;
          res_div_zero_reg <= alu_dz;
          quo_reg          <= abs_a;
          dsor_reg         <= abs_b;
          rem_reg          <= '0;
          step_reg         <= '0;
          neg_quo_reg      <= op_a_reg[OP_W-1] ^ op_b_reg[OP_W-1];
          neg_rem_reg      <= op_a_reg[OP_W-1];
        end
        S_DIVIDE: begin
          quo_reg  <= quo_step;
          rem_reg  <= rem_step;
          step_reg <= step_reg + STEP_W'(1);
          if (step_reg == LAST_STEP) res_value_reg <= div_result;
        end
        S_OUT: if (bus.res_ready) begin
          remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
          if (remaining_reg != (ADDR_W+1)'(1)) read_pointer_reg <= read_pointer_reg + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.read_pointer = read_pointer_reg;
  assign bus.res_valid    = (state_reg == S_OUT);
  assign bus.res_addr     = res_addr_reg;
  assign bus.res_opcode   = opc_reg;
  assign bus.res_value    = res_value_reg;
  assign bus.res_div_zero = res_div_zero_reg;
  assign busy             = (state_reg != S_IDLE);
  assign done             = (state_reg == S_FIN);
endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Table-driven and randomized checks of instr_exec_sequencer against a
// behavioural model of the instruction semantics and stream timing.
module tb_instr_exec_sequencer;
  logic       clk;
  logic       reset_n;
  logic       start;
  logic [4:0] start_addr;
  logic [5:0] count;
  logic       busy;
  logic       done;

  instr_exec_sequencer_if #(.OP_W(32), .RES_W(64), .ADDR_W(5)) bus ();

  instr_exec_sequencer #(.OP_W(32), .RES_W(64), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .count(count), .bus(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] mem_opc [32];
  int         mem_a   [32];
  int         mem_b   [32];

  always_comb bus.instruction_word = {mem_opc[bus.read_pointer], mem_a[bus.read_pointer],
                                      mem_b[bus.read_pointer], 64'h0123_4567_89ab_cdef};

  typedef struct {
    logic [4:0] addr;
    logic [3:0] opc;
    longint     v;
    bit         dz;
    int         dly;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int         run;
    logic [4:0] addr;
    logic [3:0] opc;
    int         a;
    int         b;
    longint     v;
    bit         dz;
  } vec_t;
  vec_t vecs[17];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int divide_delay(input logic [3:0] opc, input int b);
    return ((opc == 4'd6 || opc == 4'd7) && b != 0) ? 32 : 0;
  endfunction

  // Reference semantics: plain 64-bit signed arithmetic on the operands.
  function automatic void model(input logic [3:0] opc, input int a, input int b,
                                output longint v, output bit dz);
    longint sa = longint'(a);
    longint sb = longint'(b);
    v  = 0;
    dz = 1'b0;
    case (opc)
      4'd0: v = 0;
      4'd1: v = sa;
      4'd2: v = sb;
      4'd3: v = sa + sb;
      4'd4: v = sa - sb;
      4'd5: v = sa * sb;
      4'd6: if (b == 0) dz = 1'b1; else v = sa / sb;
      4'd7: if (b == 0) dz = 1'b1; else v = sa % sb;
      default: dz = 1'b1;
    endcase
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 7))
      0: return int'(32'h8000_0000);
      1: return int'(32'h7fff_ffff);
      2: return -1;
      3: return 0;
      4: return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic run_check(input logic [4:0] sa, input logic [5:0] cnt, input int ready_pct,
                           input int stall_first, input bit noise);
    int               k = 0;
    int               exp_valid_k;
    int               hs_last = -1;
    int               stall_left = stall_first;
    bit               done_seen = 1'b0;
    bit               stalled = 1'b0;
    logic [63:0]      held_misc = '0;
    logic signed [63:0] held_val = '0;
    exp_t             e;
    start      = 1'b1;
    start_addr = sa;
    count      = cnt;
    @(posedge clk); #1;
    start = 1'b0;
    exp_valid_k = (exp_q.size() > 0) ? 3 + exp_q[0].dly : -1;
    chk("busy_after_start", busy, 1);
    while (!done_seen && k < 3000) begin
      if (bus.res_valid && stall_left > 0) begin
        bus.res_ready = 1'b0;
        stall_left--;
      end else begin
        bus.res_ready = (ready_pct >= 100) || (int'($urandom_range(0, 99)) < ready_pct);
      end
      if (stalled) begin
        chk("hold_stable", {46'd0, bus.res_valid, bus.read_pointer, bus.res_addr,
                            bus.res_opcode, bus.res_div_zero}, held_misc);
        chk("hold_value", bus.res_value, held_val);
      end else if (k == exp_valid_k) begin
        chk("valid_time", bus.res_valid, 1);
      end else if (bus.res_valid) begin
        chk("valid_unexpected", bus.res_valid, 0);
      end
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", bus.res_valid, 0);
        end else if (bus.res_ready) begin
          e = exp_q.pop_front();
          $display("result addr=%0d rp=%0d opc=%0d value=%0d dz=%0d (exp addr=%0d value=%0d dz=%0d)",
                   bus.res_addr, bus.read_pointer, bus.res_opcode, bus.res_value,
                   bus.res_div_zero, e.addr, e.v, e.dz);
          chk("res_value", bus.res_value, e.v);
          chk("res_addr_rp", {54'd0, bus.res_addr, bus.read_pointer}, {54'd0, e.addr, e.addr});
          chk("res_opc_dz", {59'd0, bus.res_opcode, bus.res_div_zero}, {59'd0, e.opc, e.dz});
          hs_last     = k;
          exp_valid_k = (exp_q.size() > 0) ? k + 4 + exp_q[0].dly : -1;
        end
        stalled   = !bus.res_ready;
        held_misc = {46'd0, bus.res_valid, bus.read_pointer, bus.res_addr,
                     bus.res_opcode, bus.res_div_zero};
        held_val  = bus.res_value;
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        chk("done_time", k, (cnt == 0) ? 0 : hs_last + 1);
        chk("results_left", exp_q.size(), 0);
        done_seen = 1'b1;
      end
      if (noise && !done) begin
        start      = ($urandom_range(0, 3) == 0);
        start_addr = 5'($urandom);
        count      = 6'($urandom_range(0, 32));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("post_done_idle", {61'd0, done, busy, bus.res_valid}, 0);
    exp_q.delete();
  endtask

  task automatic load_run(input int r, output logic [4:0] sa, output logic [5:0] n);
    n = 0;
    sa = 0;
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].run == r) begin
        if (n == 0) sa = vecs[i].addr;
        mem_opc[vecs[i].addr] = vecs[i].opc;
        mem_a[vecs[i].addr]   = vecs[i].a;
        mem_b[vecs[i].addr]   = vecs[i].b;
        exp_q.push_back('{vecs[i].addr, vecs[i].opc, vecs[i].v, vecs[i].dz,
                          divide_delay(vecs[i].opc, vecs[i].b)});
        n++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] sa;
    logic [5:0] n;
    longint     v;
    bit         dz;

    vecs[0]  = '{0, 5'd0,  4'd3,  5,   3,  64'sd8,   1'b0};
    vecs[1]  = '{0, 5'd1,  4'd4,  -15, 7,  -64'sd22, 1'b0};
    vecs[2]  = '{0, 5'd2,  4'd5,  -4,  9,  -64'sd36, 1'b0};
    vecs[3]  = '{0, 5'd3,  4'd2,  0,   12, 64'sd12,  1'b0};
    vecs[4]  = '{1, 5'd9,  4'd6,  -15, 4,  -64'sd3,  1'b0};
    vecs[5]  = '{1, 5'd10, 4'd7,  -15, 4,  -64'sd3,  1'b0};
    vecs[6]  = '{2, 5'd9,  4'd6,  7,   0,  64'sd0,   1'b1};
    vecs[7]  = '{2, 5'd10, 4'd7,  7,   0,  64'sd0,   1'b1};
    vecs[8]  = '{3, 5'd30, 4'd6,  int'(32'h8000_0000), -1, 64'sd2147483648, 1'b0};
    vecs[9]  = '{3, 5'd31, 4'd5,  int'(32'h8000_0000), int'(32'h8000_0000), 64'sd4611686018427387904, 1'b0};
    vecs[10] = '{3, 5'd0,  4'd0,  9,   9,  64'sd0,   1'b0};
    vecs[11] = '{3, 5'd1,  4'd1,  -7,  1,  -64'sd7,  1'b0};
    vecs[12] = '{4, 5'd20, 4'd9,  5,   5,  64'sd0,   1'b1};
    vecs[13] = '{4, 5'd21, 4'd7,  15,  -4, 64'sd3,   1'b0};
    vecs[14] = '{4, 5'd22, 4'd6,  7,   -2, -64'sd3,  1'b0};
    vecs[15] = '{4, 5'd23, 4'd15, 1,   2,  64'sd0,   1'b1};
    vecs[16] = '{4, 5'd24, 4'd4,  int'(32'h8000_0000), 1, -64'sd2147483649, 1'b0};

    for (int i = 0; i < 32; i++) begin
      mem_opc[i] = 4'd0;
      mem_a[i]   = 0;
      mem_b[i]   = 0;
    end
    reset_n       = 1'b0;
    start         = 1'b0;
    start_addr    = '0;
    count         = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {46'd0, bus.res_valid, busy, done, bus.read_pointer, bus.res_addr,
                          bus.res_opcode, bus.res_div_zero}, 0);
    chk("reset_value", bus.res_value, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 5; r++) begin
      load_run(r, sa, n);
      $display("table run %0d: start_addr=%0d count=%0d", r, sa, n);
      run_check(sa, n, 100, 0, r[0]);
    end

    load_run(0, sa, n);
    $display("stall run: first result held 10 cycles");
    run_check(sa, n, 100, 10, 1'b0);

    $display("empty run: count=0");
    exp_q.delete();
    run_check(5'd17, 6'd0, 100, 0, 1'b0);

    $display("abort run: reset during DIVIDE");
    mem_opc[5] = 4'd6;
    mem_a[5]   = 100;
    mem_b[5]   = 7;
    start      = 1'b1;
    start_addr = 5'd5;
    count      = 6'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("divide_busy", {62'd0, busy, bus.res_valid}, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", {46'd0, bus.res_valid, busy, done, bus.read_pointer, bus.res_addr,
                          bus.res_opcode, bus.res_div_zero}, 0);
    chk("abort_value", bus.res_value, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", {61'd0, done, busy, bus.res_valid}, 0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    load_run(1, sa, n);
    run_check(sa, n, 100, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem_opc[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        mem_a[i]   = rand_operand();
        mem_b[i]   = rand_operand();
      end
      sa = 5'($urandom);
      n  = (r == 7) ? 6'd32 : 6'($urandom_range(0, 10));
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
        logic [4:0] ad;
        ad = sa + 5'(i);
        model(mem_opc[ad], mem_a[ad], mem_b[ad], v, dz);
        exp_q.push_back('{ad, mem_opc[ad], v, dz, divide_delay(mem_opc[ad], mem_b[ad])});
      end
      $display("random run %0d: start_addr=%0d count=%0d", r, sa, n);
      run_check(sa, n, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
